// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the fetch/decode front end: word width,
// reset vector, base opcode field encodings and the canonical NOP.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, inst} pairs. Head entry is read straight
// from storage registers, so the consumer sees no combinational path
// from the write side. Flush empties the FIFO in one cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // Status flags and qualified push/pop; a push into a full FIFO is only
    // taken when the same-cycle pop frees the slot.
    always_comb begin
        full    = (cnt == CW'(DEPTH));
        empty   = (cnt == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_data = mem[rd_ptr];
    assign count     = cnt;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches,
// buffers returned words in a prefetch FIFO and hands one instruction per
// cycle to decode. A redirect flushes the FIFO, arms a drop counter for
// stale in-flight responses and restarts fetch at the target.
//
// Handshakes: a transfer happens on a cycle where valid && ready are both
// high at the rising clock edge. imem_req_valid may fall without a transfer
// (credit change or redirect) but imem_req_addr is stable while it is high.
// imem_rsp has no ready; responses return in order, one per valid cycle.
// inst_valid/inst_ready pops the FIFO head.
module inst_fetch_unit
    import rv_pkg::*;
#(
    parameter int                      XLEN       = rv_pkg::XLEN,
    parameter logic [rv_pkg::XLEN-1:0] RESET_PC   = rv_pkg::RESET_PC,
    parameter int                      FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      inst_opcode
);

    localparam int OW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [0:0] ST_BOOT  = 1'b0;
    localparam logic [0:0] ST_FETCH = 1'b1;

    localparam logic [OW:0] DEPTH_L = (OW+1)'(FIFO_DEPTH);

    logic [0:0]         state;
    logic [0:0]         state_next;
    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    rsp_pc;
    logic [OW-1:0]      outstanding;
    logic [OW-1:0]      outstanding_next;
    logic [OW-1:0]      drop_cnt;
    logic [OW:0]        in_use;
    logic               req_accept;
    logic               rsp_keep;
    logic               rsp_drop;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [OW-1:0]      fifo_count;
    logic [2*XLEN-1:0]  fifo_head;
    logic [XLEN-1:0]    reset_base;
    logic [XLEN-1:0]    redirect_base;

    assign reset_base    = {RESET_PC[XLEN-1:2], 2'b00};
    assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};

    // Credit check, handshake qualification and response classification.
    // Slots in use = buffered words + live (non-dropped) in-flight requests.
    always_comb begin
        in_use           = {1'b0, fifo_count} + {1'b0, outstanding} - {1'b0, drop_cnt};
        imem_req_valid   = (state == ST_FETCH) && (in_use < DEPTH_L) && !redirect_valid;
        imem_req_addr    = {fetch_pc[XLEN-1:2], 2'b00};
        req_accept       = imem_req_valid && imem_req_ready;
        rsp_drop         = imem_rsp_valid && (drop_cnt != '0);
        rsp_keep         = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
        fifo_pop         = inst_valid && inst_ready && !redirect_valid;
        outstanding_next = outstanding + OW'(req_accept) - OW'(imem_rsp_valid);
    end

    // Boot FSM: one idle cycle after reset release, then fetch forever.
    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT:  state_next = ST_FETCH;
            ST_FETCH: state_next = ST_FETCH;
            default:  state_next = ST_BOOT;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Outstanding/drop counters; a redirect turns everything still in
    // flight (after this cycle's response/accept) into words to discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                drop_cnt <= outstanding_next;
            end else if (rsp_drop) begin
                drop_cnt <= drop_cnt - OW'(1);
            end
        end
    end

    // Fetch PC advances per accepted request; response PC per kept word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= reset_base;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_base;
            rsp_pc   <= redirect_base;
        end else begin
            if (req_accept) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (rsp_keep) begin
                rsp_pc <= rsp_pc + XLEN'(4);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign inst_valid  = !fifo_empty;
    assign inst_pc     = fifo_head[2*XLEN-1:XLEN];
    assign inst        = fifo_head[XLEN-1:0];
    assign inst_opcode = fifo_head[6:0];

    // The credit rule must keep a kept word from landing in a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_keep && fifo_full && !fifo_pop));

    // Memory never answers more requests than were issued.
    a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (outstanding == '0)));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: a memory model answers accepted requests
// after a programmable latency; each request carries the redirect epoch
// it was issued in, and only responses from the current epoch become
// expected instructions. A monitor pops and compares decode output.
module tb_inst_fetch_unit;

    localparam int          XL     = 32;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic          clk;
    logic          rst_n;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [XL-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [XL-1:0] imem_rsp_data;
    logic          redirect_valid;
    logic [XL-1:0] redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [XL-1:0] inst;
    logic [XL-1:0] inst_pc;
    logic [6:0]    inst_opcode;

    inst_fetch_unit #(
        .XLEN       (XL),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_opcode    (inst_opcode)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model state ----------------
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        inflight[$];
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    int          vectors;
    int          errors;
    int          cyc;
    int          epoch;
    logic [31:0] fetch_exp;
    bit          fetch_ok;
    int          lat;
    bit          rdy_rand;
    int          irdy_mode;
    bit          redir_req;
    logic [31:0] redir_tgt;
    int          acc_cnt;
    logic [31:0] first_acc_addr;
    int          pop_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        inflight.delete();
        exp_q.delete();
        fetch_exp = RST_PC;
        fetch_ok  = 1'b0;
        redir_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock of activity; called at a falling edge, returns at the next.
    task automatic cycle();
        bit   redir_now;
        bit   rsp_now;
        bit   acc;
        bit   exp_req;
        int   live;
        req_t r;
        cyc++;
        redir_now      = redir_req;
        redir_req      = 1'b0;
        redirect_valid = redir_now;
        redirect_pc    = redir_now ? redir_tgt : $urandom;
        imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        inst_ready     = (irdy_mode == 0) ? 1'b0 :
                         (irdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        rsp_now        = (inflight.size() > 0) && (inflight[0].due <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_word(inflight[0].addr) : $urandom;
        #1;
        live = 0;
        foreach (inflight[i]) if (inflight[i].epoch == epoch) live++;
        exp_req = fetch_ok && !redir_now && ((exp_q.size() + live) < DEPTH);
        check("req_valid", 64'(imem_req_valid), 64'(exp_req));
        acc = imem_req_valid && imem_req_ready;
        if (acc) check("req_addr", 64'(imem_req_addr), 64'(fetch_exp));
        #2;
        if (redir_now) begin
            epoch++;
            exp_q.delete();
            fetch_exp = {redir_tgt[31:2], 2'b00};
        end
        if (rsp_now) begin
            r = inflight.pop_front();
            if (r.epoch == epoch) exp_q.push_back({r.addr, mem_word(r.addr)});
        end
        if (acc) begin
            if (acc_cnt == 0) first_acc_addr = fetch_exp;
            inflight.push_back('{fetch_exp, epoch, cyc + lat});
            fetch_exp = fetch_exp + 32'd4;
            acc_cnt++;
        end
        fetch_ok = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1) begin
                check("inst_valid", 64'(inst_valid), 64'(exp_q.size() != 0));
                if (inst_valid && inst_ready && !redirect_valid && exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("inst_pc", 64'(inst_pc), 64'(mon_e[63:32]));
                    check("inst", 64'(inst), 64'(mon_e[31:0]));
                    check("inst_opcode", 64'(inst_opcode), 64'(mon_e[6:0]));
                    pop_cnt++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int first;
        int n;
        int p0;
        vectors   = 0;
        errors    = 0;
        cyc       = 0;
        epoch     = 0;
        acc_cnt   = 0;
        pop_cnt   = 0;
        lat       = 1;
        rdy_rand  = 1'b0;
        irdy_mode = 1;
        rst_n     = 1'b0;
        @(negedge clk);

        // Straight-line fetch, always-ready memory, 1-cycle latency.
        do_reset();
        check("reset_req_valid", 64'(imem_req_valid), 64'(0));
        check("reset_inst_valid", 64'(inst_valid), 64'(0));
        check("reset_inst", 64'(inst), 64'(0));
        check("reset_inst_pc", 64'(inst_pc), 64'(0));
        first = -1;
        for (int k = 0; k < 12; k++) begin
            if (first < 0 && inst_valid) first = k;
            cycle();
        end
        check("first_valid_cycle", 64'(first), 64'(3));

        // Decode stalled: fetch fills FIFO and stops, then drains in order.
        do_reset();
        irdy_mode = 0;
        acc_cnt   = 0;
        repeat (12) cycle();
        check("stall_accepts", 64'(acc_cnt), 64'(DEPTH));
        check("stall_req_valid", 64'(imem_req_valid), 64'(0));
        irdy_mode = 1;
        p0 = pop_cnt;
        repeat (4) cycle();
        check("stall_drained_two", 64'((pop_cnt - p0) >= 2), 64'(1));

        // Redirect with two in flight and one response in the redirect cycle.
        lat = 3;
        n   = 0;
        while (!(inflight.size() == 2 && inflight[0].epoch == epoch &&
                 inflight[1].epoch == epoch && inflight[0].due <= cyc + 1) && n < 100) begin
            cycle();
            n++;
        end
        check("redirect_setup_found", 64'(n < 100), 64'(1));
        redir_req = 1'b1;
        redir_tgt = 32'h0000_0100;
        cycle();
        check("post_redirect_inst_valid", 64'(inst_valid), 64'(0));
        n = 0;
        while (!inst_valid && n < 50) begin cycle(); n++; end
        check("redirect_pc_0x100", 64'(inst_pc), 64'(32'h100));

        // Unaligned target is forced to a word boundary.
        repeat (5) cycle();
        redir_req = 1'b1;
        redir_tgt = 32'h0000_0203;
        cycle();
        n = 0;
        while (!inst_valid && n < 50) begin cycle(); n++; end
        check("redirect_pc_0x200", 64'(inst_pc), 64'(32'h200));

        // Random memory readiness, 3-cycle latency, random decode stalls.
        rdy_rand  = 1'b1;
        irdy_mode = 2;
        p0 = pop_cnt;
        n  = 0;
        while ((pop_cnt - p0) < 200 && n < 4000) begin cycle(); n++; end
        check("random_200_instructions", 64'((pop_cnt - p0) >= 200), 64'(1));

        // Random redirects, including back-to-back ones, at mixed latency.
        for (int k = 0; k < 400; k++) begin
            if (k == 200) lat = 2;
            if ($urandom_range(0, 15) == 0) begin
                redir_req = 1'b1;
                redir_tgt = $urandom;
            end
            cycle();
        end
        redir_req = 1'b1;
        redir_tgt = 32'h0000_0400;
        cycle();
        redir_req = 1'b1;
        redir_tgt = 32'h0000_0800;
        cycle();
        n = 0;
        while (!inst_valid && n < 50) begin cycle(); n++; end
        check("back_to_back_last_wins", 64'(inst_pc), 64'(32'h800));

        // Reset asserted mid-stream with the FIFO full.
        rdy_rand  = 1'b0;
        irdy_mode = 0;
        lat       = 1;
        n = 0;
        while (exp_q.size() < DEPTH && n < 50) begin cycle(); n++; end
        check("fill_before_reset", 64'(exp_q.size()), 64'(DEPTH));
        #4;
        rst_n = 1'b0;
        #1;
        check("async_rst_req_valid", 64'(imem_req_valid), 64'(0));
        check("async_rst_inst_valid", 64'(inst_valid), 64'(0));
        check("async_rst_inst", 64'(inst), 64'(0));
        check("async_rst_inst_pc", 64'(inst_pc), 64'(0));
        check("async_rst_opcode", 64'(inst_opcode), 64'(0));
        do_reset();
        irdy_mode = 1;
        acc_cnt   = 0;
        repeat (8) cycle();
        check("post_reset_first_req", 64'(first_acc_addr), 64'(RST_PC));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
